// File: rtl/mdu_if.sv
// mdu_if: EX-stage handshake between the pipeline and the multiply/divide unit.
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        exe_stall_req;
  logic        done;
  logic [63:0] result;
  modport master (output start, op, src1, src2, flush, input exe_stall_req, done, result);
  modport slave (input start, op, src1, src2, flush, output exe_stall_req, done, result);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: RV64 M-extension controller, shift-add multiply and restoring divide, one bit per cycle.
// Define MDU_FAST_MUL_EN to compute every multiply in a single combinational cycle.
module mdu_ctrl (
  input logic  clk_i,
  input logic  rst_ni,
  mdu_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e state_q;
  logic [6:0] cnt_q;
  logic [3:0] op_q, op;
  logic neg_q, done_q, w, mul, rem, s1, s2, rsv, dz, ovf, neg, spec, mul_q, ge;
  logic [63:0] a_q, result_q, x1, x2, m1, m2, spec_res, spec_div;
  logic [64:0] hi_m, r_sh, diff;
  logic [128:0] acc_q, acc_ld, acc_step;

  // Products arrive as a 128-bit value (W products pre-shifted by 32); quotient/remainder as {rem, quo}.
  function automatic logic [63:0] finish(input logic [3:0] o, input logic ng, input logic [127:0] a);
    logic [127:0] p;
    logic [63:0] v, r;
    p = o[3] ? {32'd0, a[127:32]} : a;
    p = ng ? -p : p;
    v = (o == 4'd6 || o == 4'd7 || o == 4'd11 || o == 4'd12) ? a[127:64] : a[63:0];
    v = ng ? -v : v;
    r = (o < 4'd4 || o == 4'd8) ? ((o == 4'd0 || o == 4'd8) ? p[63:0] : p[127:64]) : v;
    return o[3] ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  assign op  = bus_io.op;
  assign w   = op[3];
  assign rsv = op >= 4'd13;
  assign mul = op < 4'd4 || op == 4'd8;
  assign rem = op == 4'd6 || op == 4'd7 || op == 4'd11 || op == 4'd12;
  assign s1  = op == 4'd1 || op == 4'd2 || op == 4'd4 || op == 4'd6 || op == 4'd9 || op == 4'd11;
  assign s2  = op == 4'd1 || op == 4'd4 || op == 4'd6 || op == 4'd9 || op == 4'd11;
  assign x1  = w ? {{32{s1 & bus_io.src1[31]}}, bus_io.src1[31:0]} : bus_io.src1;
  assign x2  = w ? {{32{s2 & bus_io.src2[31]}}, bus_io.src2[31:0]} : bus_io.src2;
  assign m1  = (s1 & x1[63]) ? -x1 : x1;
  assign m2  = (s2 & x2[63]) ? -x2 : x2;
  assign neg = (s1 & x1[63]) ^ (~rem & s2 & x2[63]);
  assign dz  = ~mul & ~rsv & (x2 == '0);
  assign ovf = ~mul & ~rsv & s1 & (x1 == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) & (&x2);
  assign spec_div = rsv ? '0 : dz ? (rem ? (w ? {{32{bus_io.src1[31]}}, bus_io.src1[31:0]} : bus_io.src1) : '1) : (rem ? '0 : x1);
  // W dividends sit in the upper half so the MSB-first divider needs only 32 steps.
  assign acc_ld = {65'd0, mul ? m2 : (w ? {m1[31:0], 32'd0} : m1)};
`ifdef MDU_FAST_MUL_EN
  logic [127:0] prod;
  assign prod     = {64'd0, m1} * {64'd0, m2};
  assign spec     = rsv | dz | ovf | mul;
  assign spec_res = mul ? finish(op, neg, w ? {prod[95:0], 32'd0} : prod) : spec_div;
`else
  assign spec     = rsv | dz | ovf;
  assign spec_res = spec_div;
`endif
  assign mul_q    = op_q < 4'd4 || op_q == 4'd8;
  assign hi_m     = acc_q[128:64] + (acc_q[0] ? {1'b0, a_q} : 65'd0);
  assign r_sh     = acc_q[127:63];
  assign ge       = r_sh >= {1'b0, a_q};
  assign diff     = r_sh - {1'b0, a_q};
  assign acc_step = mul_q ? {1'b0, hi_m, acc_q[63:1]} : {ge ? diff : r_sh, acc_q[62:0], ge};

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (bus_io.flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else case (state_q)
      IDLE: if (bus_io.start) begin
        op_q    <= op;
        neg_q   <= neg;
        a_q     <= mul ? m1 : m2;
        acc_q   <= acc_ld;
        cnt_q   <= spec ? 7'd0 : (w ? 7'd32 : 7'd64);
        state_q <= spec ? DONE : CALC;
        done_q  <= spec;
        if (spec) result_q <= spec_res;
      end
      CALC: begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          state_q  <= DONE;
          done_q   <= 1'b1;
          result_q <= finish(op_q, neg_q, acc_step[127:0]);
        end
      end
      default: begin
        state_q <= IDLE;
        done_q  <= 1'b0;
      end
    endcase

  assign bus_io.exe_stall_req = rst_ni & ~bus_io.flush & ((state_q == IDLE & bus_io.start) | state_q == CALC);
  assign bus_io.done          = done_q & ~bus_io.flush;
  assign bus_io.result        = result_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: random and directed M-extension ops checked by a scoreboard against an arithmetic model.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mdu_if bus();
  mdu_ctrl dut (.clk_i(clk), .rst_ni(rst_n), .bus_io(bus));

  typedef struct {logic [63:0] res; int stalls;} exp_t;
  exp_t sbq[$];
  exp_t got;
  int errors = 0, checks = 0, stall_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    logic signed [63:0] sa, sb, q, r;
    logic signed [31:0] sa32, sb32, q32, r32;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
    case (op)
      4'd0: return a * b;
      4'd1, 4'd2, 4'd3: begin
        if (op == 4'd3) pa = {64'd0, a}; else pa = sa;
        if (op == 4'd1) pb = sb; else pb = {64'd0, b};
        p = pa * pb;
        return p[127:64];
      end
      4'd4, 4'd6: begin
        if (b == 0) return op == 4'd4 ? '1 : a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return op == 4'd4 ? a : 64'd0;
        q = sa / sb; r = sa % sb;
        return op == 4'd4 ? q : r;
      end
      4'd5, 4'd7: begin
        if (b == 0) return op == 4'd5 ? '1 : a;
        return op == 4'd5 ? a / b : a % b;
      end
      4'd8: return sx(a[31:0] * b[31:0]);
      4'd9, 4'd11: begin
        if (b[31:0] == 0) return op == 4'd9 ? '1 : sx(a[31:0]);
        if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) return op == 4'd9 ? sx(a[31:0]) : 64'd0;
        q32 = sa32 / sb32; r32 = sa32 % sb32;
        return sx(op == 4'd9 ? q32 : r32);
      end
      4'd10, 4'd12: begin
        if (b[31:0] == 0) return op == 4'd10 ? '1 : sx(a[31:0]);
        return sx(op == 4'd10 ? a[31:0] / b[31:0] : a[31:0] % b[31:0]);
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_stalls(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic is_mul, zero, ovf;
    is_mul = op <= 4'd3 || op == 4'd8;
    zero = op[3] ? b[31:0] == 0 : b == 0;
    ovf = ((op == 4'd4 || op == 4'd6) && a == 64'h8000_0000_0000_0000 && b == '1) ||
          ((op == 4'd9 || op == 4'd11) && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
    if (op >= 4'd13 || (!is_mul && (zero || ovf))) return 1;
`ifdef MDU_FAST_MUL_EN
    if (is_mul) return 1;
`endif
    return op[3] ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 100));
      4: return sx($urandom);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Presents one instruction and holds it in EX until the unit stops stalling.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int n;
    e.res = ref_res(op, a, b);
    e.stalls = ref_stalls(op, a, b);
    sbq.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.src1 = a; bus.src2 = b;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!bus.exe_stall_req) break;
    end
    if (n == 200) chk("stall_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n || bus.flush) stall_cnt = 0;
    else begin
      if (bus.exe_stall_req) stall_cnt++;
      if (bus.done) begin
        if (sbq.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          got = sbq.pop_front();
          chk("result", bus.result, got.res);
          chk("stall_cycles", 64'(stall_cnt), 64'(got.stalls));
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [3:0] rop;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.src1 = '0; bus.src2 = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 64'(bus.exe_stall_req), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_result", bus.result, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(4'd0, 64'd7, -64'd3);
    issue(4'd4, -64'd20, 64'd6);
    issue(4'd6, -64'd20, 64'd6);
    issue(4'd5, 64'd5, 64'd0);
    issue(4'd7, 64'd5, 64'd0);
    issue(4'd4, 64'h8000_0000_0000_0000, -64'd1);
    issue(4'd9, 64'h0000_0001_8000_0000, -64'd1);
    issue(4'd8, 64'h10000, 64'h10000);
    issue(4'd3, '1, 64'd2);
    issue(4'd5, 64'd100, 64'd7);
    issue(4'd14, 64'd9, 64'd9);
    issue(4'd1, -64'd3, 64'd7);
    issue(4'd2, -64'd1, '1);
    issue(4'd12, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0);
    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 15));
      issue(rop, pick(), pick());
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b1; bus.op = 4'd4; bus.src1 = 64'd1000; bus.src2 = 64'd3;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("calc_stall", 64'(bus.exe_stall_req), 64'd1);
    @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(bus.exe_stall_req), 64'd0);
    @(posedge clk);
    #1 bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("flush_idle", 64'(bus.exe_stall_req), 64'd0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    issue(4'd5, 64'd100, 64'd7);
    bus.start = 1'b1; bus.op = 4'd0; bus.src1 = 64'd3; bus.src2 = 64'd5;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 64'(bus.exe_stall_req), 64'd0);
    chk("async_rst_done", 64'(bus.done), 64'd0);
    chk("async_rst_result", bus.result, 64'd0);
    bus.start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(4'd8, 64'd6, 64'd7);
    issue(4'd7, 64'd100, 64'd7);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
